seg_scheduler: RTL and testbench
================================

SEG_SCHEDULER -- requirements
Module: seg_scheduler

Interface
REQ-001 Parameter SCAN_DIV, default 50000: sysclk cycles per digit scan tick (minimum 2).
REQ-002 Parameter DWELL_FRAMES, default 500: full 4-digit frames each page is shown before auto-advance (minimum 1).
REQ-003 sysclk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 src_data0..src_data3  input  32 each  display requesters (RAM word, PC, register, etc.).
REQ-006 src_valid  input  4  bit i high = requester i has displayable data.
REQ-007 hold  input  1  level; freezes the dwell count, so the current page is held.
REQ-008 next  input  1  one-cycle pulse; requests an immediate page advance.
REQ-009 AN  output  4  one-hot digit enable, active high; AN[0] = least significant digit.
REQ-010 digi  output  8  segments {dp,g,f,e,d,c,b,a}, active high.
REQ-011 page  output  3  current page {src_idx[1:0], half}; half 0 = bits [15:0], half 1 = bits [31:16].
REQ-012 blank  output  1  high when no requester is valid and the display is dark.

Function
REQ-013 A tick counter shall count 0..SCAN_DIV-1 and assert a one-cycle scan tick on wrap.
REQ-014 A digit index shall run 0,1,2,3,0,...; it advances on each scan tick. A frame is 4 consecutive ticks that begin at digit 0.
REQ-015 Sequencing: AN and digi shall be registered and update in the same cycle as the scan tick. The nibble shown for digit index d shall be snapshot[4d+3:4d].
REQ-016 At each frame start (the tick selecting digit 0), the block shall capture the 16-bit half of src_data[src_idx] named by page into snapshot. Data is therefore stable within a frame.
REQ-017 Hex encoding, 0-F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 (segments g..a in digi[6:0]).
REQ-018 digi[7] (dp) shall be 1 only on digit 3 when half=1; it is 0 otherwise.
REQ-019 State machine states:
  - BLANK: AN=0, digi=0, blank=1.
  - SHOW: normal scan, blank=0.
REQ-020 BLANK->SHOW occurs at the next frame start when any src_valid bit is set. page then goes to the lowest valid index with half=0.
REQ-021 SHOW->BLANK occurs at a frame start when src_valid==0.
REQ-022 The dwell counter shall increment at each frame end while hold=0 and the state is SHOW. On reaching DWELL_FRAMES it sets an advance-pending flag and clears itself.
REQ-023 A next pulse shall set advance-pending in any state. next during BLANK is discarded at the BLANK->SHOW transition.
REQ-024 Advance-pending shall be consumed only at a frame start, so no page change tears a frame. A consumed advance clears the dwell counter.
REQ-025 Advance order: (i,0)->(i,1)->(j,0), where j is the next valid index after i in round-robin order (mod 4). If i is the only valid source, (i,1)->(i,0).
REQ-026 If the current src_idx is invalid at a frame start, the block shall advance immediately to (j,0) per REQ-025 whether or not an advance is pending.
REQ-027 Several advance causes in one frame (dwell expiry, one or more next pulses, invalid source) shall produce exactly one page step.
REQ-028 hold shall not block next or the invalid-source skip.
REQ-029 Changes on src_data between frame starts shall not affect the displayed digits.

Reset
REQ-030 While reset=1 at a rising edge the block shall clear all state:
  - tick counter, digit index, dwell counter, advance-pending = 0
  - snapshot = 0, page = 3'b000
  - state = BLANK; AN = 4'b0000, digi = 8'h00, blank = 1
REQ-031 Reset asserted mid-frame or mid-dwell shall take effect at that edge, with no partial frame completed. After reset release the first scan tick occurs SCAN_DIV cycles later.

Verification (SCAN_DIV=4, DWELL_FRAMES=2 unless noted)
REQ-032 Reset, src_valid=0 for 200 cycles -> AN=0, digi=0, blank=1 throughout; page=0.
REQ-033 src_valid=4'b0001, src_data0=32'h1234ABCD -> digits 0..3 show 5E,39,7C,77 with AN=1,2,4,8. After 2 frames page=3'b001, digits show 66,4F,5B,06, and dp is lit on AN=8.
REQ-034 src_valid=4'b0101, hold=1 -> page stays 000. A next pulse mid-frame -> page becomes 001 exactly at the next frame start, not earlier. Another next -> page becomes 100, skipping source 1.
REQ-035 Showing page 100, drop src_valid[2] -> at the next frame start page becomes 000. Then drop src_valid to 0 -> BLANK at the following frame start.
REQ-036 next pulse in the same cycle as dwell expiry -> exactly one page step. Change src_data0 mid-frame -> the frame's remaining digits still show old data.
REQ-037 Assert reset for 1 cycle mid-frame while showing page 011 -> next edge gives AN=0, digi=0, page=000, blank=1. Re-display starts at digit 0.

Source files
------------

// File: rtl/seg_scheduler.sv
// Four-digit seven-segment scan driver that pages through up to four 32-bit
// requesters, one 16-bit half per page, switching pages only on frame boundaries.
module seg_scheduler #(
  parameter int SCAN_DIV     = 50000,
  parameter int DWELL_FRAMES = 500
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [31:0] src_data0,
  input  logic [31:0] src_data1,
  input  logic [31:0] src_data2,
  input  logic [31:0] src_data3,
  input  logic [3:0]  src_valid,
  input  logic        hold,
  input  logic        next,
  output logic [3:0]  AN,
  output logic [7:0]  digi,
  output logic [2:0]  page,
  output logic        blank
);

  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES + 1) : 1;

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t          r_state;
  logic [TW-1:0]   r_tickCnt;
  logic [1:0]      r_digit;
  logic [DW-1:0]   r_dwell;
  logic            r_pending;
  logic [15:0]     r_snap;
  logic [2:0]      r_page;
  logic [3:0]      r_an;
  logic [7:0]      r_digi;

  state_t          w_stateNext;
  logic            w_tick;
  logic            w_frameStart;
  logic            w_frameEnd;
  logic [DW-1:0]   w_dwellNext;
  logic            w_pendingNext;
  logic [2:0]      w_pageNext;
  logic [31:0]     w_srcWord;
  logic [15:0]     w_snapNext;
  logic [3:0]      w_nibble;
  logic [3:0]      w_anNext;
  logic [7:0]      w_digiNext;

  function automatic logic [6:0] hexSeg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Round-robin search starting after cur; falls back to cur when it is the only valid source.
  function automatic logic [1:0] nextValid(input logic [1:0] cur, input logic [3:0] v);
    logic [1:0] res;
    logic [1:0] cand;
    res = cur;
    for (int k = 3; k >= 1; k--) begin
      cand = cur + 2'(k);
      if (v[cand]) res = cand;
    end
    return res;
  endfunction

  function automatic logic [1:0] lowestValid(input logic [3:0] v);
    logic [1:0] res;
    res = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (v[k]) res = 2'(k);
    end
    return res;
  endfunction

  // Page sequencing: every advance cause is folded into one step taken at frame start.
  always_comb begin
    w_tick        = (r_tickCnt == TW'(SCAN_DIV - 1));
    w_frameStart  = w_tick && (r_digit == 2'd0);
    w_frameEnd    = w_tick && (r_digit == 2'd3);
    w_stateNext   = r_state;
    w_pageNext    = r_page;
    w_pendingNext = r_pending | next;
    w_dwellNext   = r_dwell;

    if (w_frameEnd && (r_state == ST_SHOW) && !hold) begin
      if (r_dwell == DW'(DWELL_FRAMES - 1)) begin
        w_dwellNext   = '0;
        w_pendingNext = 1'b1;
      end else begin
        w_dwellNext = r_dwell + DW'(1);
      end
    end

    if (w_frameStart) begin
      if (r_state == ST_BLANK) begin
        if (src_valid != 4'b0000) begin
          w_stateNext   = ST_SHOW;
          w_pageNext    = {lowestValid(src_valid), 1'b0};
          w_pendingNext = 1'b0;
          w_dwellNext   = '0;
        end
      end else if (src_valid == 4'b0000) begin
        w_stateNext = ST_BLANK;
      end else if (!src_valid[r_page[2:1]]) begin
        w_pageNext    = {nextValid(r_page[2:1], src_valid), 1'b0};
        w_pendingNext = 1'b0;
        w_dwellNext   = '0;
      end else if (r_pending || next) begin
        w_pageNext    = r_page[0] ? {nextValid(r_page[2:1], src_valid), 1'b0}
                                  : {r_page[2:1], 1'b1};
        w_pendingNext = 1'b0;
        w_dwellNext   = '0;
      end
    end
  end

  // Digit 0 of a frame must already show the freshly captured snapshot.
  always_comb begin
    case (w_pageNext[2:1])
      2'd0:    w_srcWord = src_data0;
      2'd1:    w_srcWord = src_data1;
      2'd2:    w_srcWord = src_data2;
      default: w_srcWord = src_data3;
    endcase
    w_snapNext = r_snap;
    if (w_frameStart) w_snapNext = w_pageNext[0] ? w_srcWord[31:16] : w_srcWord[15:0];
    case (r_digit)
      2'd0:    w_nibble = w_snapNext[3:0];
      2'd1:    w_nibble = w_snapNext[7:4];
      2'd2:    w_nibble = w_snapNext[11:8];
      default: w_nibble = w_snapNext[15:12];
    endcase
    w_anNext   = r_an;
    w_digiNext = r_digi;
    if (w_tick) begin
      if (w_stateNext == ST_SHOW) begin
        w_anNext   = 4'b0001 << r_digit;
        w_digiNext = {(r_digit == 2'd3) && w_pageNext[0], hexSeg(w_nibble)};
      end else begin
        w_anNext   = 4'b0000;
        w_digiNext = 8'h00;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state   <= ST_BLANK;
      r_tickCnt <= '0;
      r_digit   <= 2'd0;
      r_dwell   <= '0;
      r_pending <= 1'b0;
      r_snap    <= 16'h0000;
      r_page    <= 3'b000;
      r_an      <= 4'b0000;
      r_digi    <= 8'h00;
    end else begin
      r_state   <= w_stateNext;
      r_tickCnt <= w_tick ? '0 : r_tickCnt + TW'(1);
      r_digit   <= w_tick ? r_digit + 2'd1 : r_digit;
      r_dwell   <= w_dwellNext;
      r_pending <= w_pendingNext;
      r_snap    <= w_snapNext;
      r_page    <= w_pageNext;
      r_an      <= w_anNext;
      r_digi    <= w_digiNext;
    end
  end

  assign AN    = r_an;
  assign digi  = r_digi;
  assign page  = r_page;
  assign blank = (r_state == ST_BLANK);

endmodule

// File: tb/tb_seg_scheduler.sv
// Randomized scoreboard bench for seg_scheduler: a frame-level reference model
// queues the expected outputs per clock and a monitor compares them independently.
module tb_seg_scheduler;

  localparam int SD = 4;
  localparam int DF = 2;

  logic        sysclk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] srcData [4];
  logic [3:0]  srcValid = 4'b0000;
  logic        hold = 1'b0;
  logic        next = 1'b0;
  logic [3:0]  AN;
  logic [7:0]  digi;
  logic [2:0]  page;
  logic        blank;

  always #5 sysclk = ~sysclk;

  seg_scheduler #(.SCAN_DIV(SD), .DWELL_FRAMES(DF)) dut (
    .sysclk(sysclk), .reset(reset),
    .src_data0(srcData[0]), .src_data1(srcData[1]),
    .src_data2(srcData[2]), .src_data3(srcData[3]),
    .src_valid(srcValid), .hold(hold), .next(next),
    .AN(AN), .digi(digi), .page(page), .blank(blank)
  );

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [7:0] digi;
    logic [2:0] page;
    logic       blank;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   passes = 0;
  int   drvCyc = 0;
  int   monCyc = 0;

  logic [6:0] segTab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state: cycles since reset release, shown page, queued advance, dwell frames.
  int          mCycles;
  bit          mShow;
  int          mSrc;
  int          mHalf;
  bit          mPend;
  int          mFrames;
  logic [15:0] mSnap;
  logic [3:0]  mAn;
  logic [7:0]  mDigi;

  function automatic int nextAfter(int i, logic [3:0] v);
    for (int k = 1; k <= 4; k++) if (v[(i + k) % 4]) return (i + k) % 4;
    return i;
  endfunction

  task automatic checkOutput(input string name, input logic [3:0] eAn, input logic [7:0] eDigi,
                             input logic [2:0] ePage, input logic eBlank);
    checks++;
    if (AN === eAn && digi === eDigi && page === ePage && blank === eBlank) passes++;
    else $display("[TB] FAIL %s t=%0t: got AN=%b digi=%h page=%b blank=%b, want AN=%b digi=%h page=%b blank=%b",
                  name, $time, AN, digi, page, blank, eAn, eDigi, ePage, eBlank);
  endtask

  // Advances the model across the coming rising edge using the inputs just driven.
  task automatic modelStep();
    int tickNo;
    int dig;
    logic [31:0] w;
    exp_t e;
    if (reset) begin
      mCycles = 0; mShow = 0; mSrc = 0; mHalf = 0; mPend = 0; mFrames = 0;
      mSnap = 16'h0; mAn = 4'h0; mDigi = 8'h00;
    end else begin
      mCycles++;
      if (next) mPend = 1;
      if (mCycles % SD == 0) begin
        tickNo = mCycles / SD - 1;
        dig = tickNo % 4;
        if (dig == 0) begin
          if (!mShow) begin
            if (srcValid != 0) begin
              mShow = 1; mHalf = 0; mPend = 0; mFrames = 0;
              mSrc = nextAfter(3, srcValid);
            end
          end else if (srcValid == 0) begin
            mShow = 0;
          end else if (!srcValid[mSrc]) begin
            mSrc = nextAfter(mSrc, srcValid); mHalf = 0; mPend = 0; mFrames = 0;
          end else if (mPend) begin
            if (mHalf == 0) mHalf = 1;
            else begin mSrc = nextAfter(mSrc, srcValid); mHalf = 0; end
            mPend = 0; mFrames = 0;
          end
          w = srcData[mSrc];
          mSnap = (mHalf == 1) ? w[31:16] : w[15:0];
        end
        if (dig == 3 && mShow && !hold) begin
          mFrames++;
          if (mFrames == DF) begin mPend = 1; mFrames = 0; end
        end
        if (mShow) begin
          mAn = 4'(1 << dig);
          mDigi = {(dig == 3 && mHalf == 1), segTab[(mSnap >> (4 * dig)) & 16'hF]};
        end else begin
          mAn = 4'h0; mDigi = 8'h00;
        end
      end
    end
    e.cyc = drvCyc; e.an = mAn; e.digi = mDigi;
    e.page = {2'(mSrc), 1'(mHalf)}; e.blank = !mShow;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input bit rst, input logic [3:0] v, input bit h, input bit n);
    reset = rst; srcValid = v; hold = h; next = n;
    drvCyc++;
    modelStep();
    @(posedge sysclk);
    #1;
  endtask

  always @(posedge sysclk) monCyc++;

  always @(negedge sysclk) begin
    while (expQ.size() > 0 && expQ[0].cyc <= monCyc) begin
      exp_t e;
      e = expQ.pop_front();
      if (e.cyc < monCyc) begin
        checks++;
        $display("[TB] FAIL stale: entry for cycle %0d still queued at cycle %0d", e.cyc, monCyc);
      end else begin
        checkOutput("scoreboard", e.an, e.digi, e.page, e.blank);
      end
    end
  end

  logic [7:0] firstDigi [12] = '{8'h5E, 8'h39, 8'h7C, 8'h77, 8'h5E, 8'h39, 8'h7C, 8'h77,
                                 8'h66, 8'h4F, 8'h5B, 8'h86};
  logic [2:0] firstPage [12] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                                 3'b001, 3'b001, 3'b001, 3'b001};

  initial begin
    logic [3:0] v;
    bit h;
    for (int i = 0; i < 4; i++) srcData[i] = 32'h0;

    for (int c = 0; c < 3; c++) applyStimulus(1, 4'b0000, 0, 0);
    for (int c = 0; c < 200; c++) applyStimulus(0, 4'b0000, 0, 0);
    checkOutput("idle blank", 4'h0, 8'h00, 3'b000, 1'b1);

    srcData[0] = 32'h1234ABCD;
    applyStimulus(1, 4'b0001, 0, 0);
    for (int c = 1; c <= 48; c++) begin
      applyStimulus(0, 4'b0001, 0, 0);
      if (c % SD == 0)
        checkOutput("single source", 4'(1 << ((c / SD - 1) % 4)), firstDigi[c / SD - 1],
                    firstPage[c / SD - 1], 1'b0);
    end

    srcData[2] = 32'hFEDC0987;
    for (int c = 0; c < 120; c++) applyStimulus(0, 4'b0101, 1, (c == 30 || c == 70));
    for (int c = 0; c < 40; c++) applyStimulus(0, 4'b0001, 1, 0);
    for (int c = 0; c < 20; c++) applyStimulus(0, 4'b0000, 0, 0);

    v = 4'b0011;
    h = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(63) == 0) v = 4'($urandom_range(15));
      if ($urandom_range(99) == 0) h = !h;
      for (int i = 0; i < 4; i++) if ($urandom_range(7) == 0) srcData[i] = $urandom();
      applyStimulus($urandom_range(499) == 0, v, h, $urandom_range(39) == 0);
    end
    applyStimulus(0, v, h, 0);

    @(negedge sysclk);
    #1;
    if (expQ.size() != 0) begin
      checks++;
      $display("[TB] FAIL drain: %0d expected entries never compared, want 0", expQ.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
